fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Fetch stage feeding the IF/ID register.
- Holds the architectural fetch PC and issues one instruction-memory request at a time over a req/ready + rvalid bus.
- Captures the returned word into the IF/ID register for decode.
- Advances the PC to the combinational next-PC value (branch/jump/jr/exception/eret already resolved) when decode consumes the instruction, or on a flush.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset (word aligned).
- NOP_INSTR, 32'h0000_0000, value driven on if_instr when no valid instruction.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- nextpc  input  32  next fetch address from next-PC logic; bits [1:0] ignored (treated as 0).
- flush  input  1  redirect: discard in-flight/held instruction, pc <= nextpc.
- id_stall  input  1  decode cannot accept/consume the IF/ID instruction this cycle.
- imem_req  output  1  request valid.
- imem_addr  output  32  request address, {pc[31:2],2'b00}.
- imem_ready  input  1  request accepted this cycle when imem_req=1.
- imem_rvalid  input  1  read data valid (exactly one per accepted request, at least 1 cycle later).
- imem_rdata  input  32  read data.
- pc  output  32  current fetch PC register.
- if_valid  output  1  IF/ID holds a valid instruction.
- if_pc  output  32  address of IF/ID instruction (drives next-PC logic pc input).
- if_instr  output  32  IF/ID instruction word.
- fetch_count  output  32  instructions delivered to IF/ID since reset.

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, state=REQ, discard=0, if_valid=0, if_pc=RESET_PC, if_instr=NOP_INSTR, fetch_count=0. Overrides all other inputs, including mid-transaction; any later rvalid for a pre-reset request is ignored while in REQ.
- imem_req=1 only in state REQ. imem_addr=pc always.
- States: REQ, WAIT, FULL.
- REQ:
  - flush=1: pc<=nextpc. If imem_ready=1 as well: the old address is accepted, so go to WAIT with discard<=1. Otherwise stay in REQ; the address may change before acceptance.
  - Else imem_ready=1: go to WAIT.
- WAIT:
  - imem_rvalid=1 with discard=1 (or flush=1 in the same cycle): drop the data, discard<=0, go to REQ.
  - imem_rvalid=1 otherwise: if_valid<=1, if_pc<=pc, if_instr<=imem_rdata, fetch_count<=fetch_count+1 (mod 2^32), go to FULL.
  - flush=1 without rvalid: pc<=nextpc, discard<=1, stay in WAIT.
- FULL:
  - flush=1: if_valid<=0, if_instr<=NOP_INSTR, pc<=nextpc, go to REQ.
  - Else id_stall=0: decode consumes, pc<=nextpc, if_valid<=0, if_instr<=NOP_INSTR, go to REQ.
  - Else hold all outputs.
- Priorities: rst > flush > consume/capture.
- Flush with WAIT+rvalid in the same cycle: pc<=nextpc; the word is dropped.
- imem_rvalid outside WAIT is ignored.
- Best-case throughput: ready same cycle, rvalid next cycle, no stall gives 1 instruction per 3 cycles (REQ, WAIT, FULL).
- The pc register only changes on reset, flush, or consume. if_pc is stable while FULL.
- PC arithmetic is done by the next-PC logic; this block adds nothing. Wrap-around of nextpc is passed through unchanged.

Test Plan:
- Reset, RESET_PC=0, memory ready=1 with rvalid after 1 cycle returning 32'h2008_0005 -> imem_addr=0 at cycle 0; if_valid=1, if_pc=0, if_instr=32'h2008_0005 at cycle 2; with nextpc=4, imem_addr=4 at cycle 3; fetch_count=1.
- imem_ready held 0 for 4 cycles -> imem_req=1 and imem_addr constant for all 4 cycles; WAIT entered only after ready=1.
- FULL with id_stall=1 for 3 cycles -> if_valid/if_pc/if_instr unchanged, pc unchanged, no new request; stall drop with nextpc=32'h40 -> next request addr 32'h40.
- flush in WAIT (nextpc=32'h8000_0180), rvalid 2 cycles later with 32'hDEAD_BEEF -> word discarded, if_valid stays 0, next request addr 32'h8000_0180, fetch_count unchanged.
- flush and imem_ready same cycle in REQ (pc=8, nextpc=32'h100) -> addr 8 accepted, its response dropped, next request addr 32'h100.
- rst asserted in WAIT with a late rvalid arriving the following cycle -> outputs at reset values, the late rvalid ignored, imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC register, imem request/response, IF/ID register
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] nextpc,
  input  logic        flush,
  input  logic        id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        discard;
  logic [31:0] nextpc_al;
  logic        capture;
  logic        release_ifid;
  logic        pc_load;

  // Low address bits are never meaningful for word fetches.
  assign nextpc_al = nextpc & ALIGN_MASK;

  // A returned word is kept only if nothing redirected fetch since the request was accepted.
  assign capture      = (state == ST_WAIT) && imem_rvalid && !discard && !flush;
  // IF/ID empties when decode takes the instruction or a redirect kills it.
  assign release_ifid = (state == ST_FULL) && (flush || !id_stall);
  // The PC moves only on a redirect or when decode consumes the current instruction.
  assign pc_load      = ((state != ST_FULL) && flush) || release_ifid;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_REQ;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: a flush in REQ does not stop an acceptance of the old address.
  always_comb begin
    state_nx = state;
    case (state)
      ST_REQ: begin
        if (imem_ready) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid) state_nx = (discard || flush) ? ST_REQ : ST_FULL;
      end
      ST_FULL: begin
        if (flush || !id_stall) state_nx = ST_REQ;
      end
      default: state_nx = ST_REQ;
    endcase
  end

  // Bus outputs: one request at a time, always at the current fetch PC.
  always_comb begin
    imem_req  = (state == ST_REQ);
    imem_addr = pc & ALIGN_MASK;
  end

  // Fetch PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (pc_load) begin
      pc <= nextpc_al;
    end
  end

  // Discard flag marks the outstanding response as belonging to a redirected-away address.
  always_ff @(posedge clk) begin
    if (rst) begin
      discard <= 1'b0;
    end else begin
      case (state)
        ST_REQ:  if (flush && imem_ready) discard <= 1'b1;
        ST_WAIT: begin
          if (imem_rvalid)  discard <= 1'b0;
          else if (flush)   discard <= 1'b1;
        end
        default: discard <= discard;
      endcase
    end
  end

  // IF/ID register and delivered-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid    <= 1'b0;
      if_pc       <= RESET_PC;
      if_instr    <= NOP_INSTR;
      fetch_count <= 32'd0;
    end else if (capture) begin
      if_valid    <= 1'b1;
      if_pc       <= pc;
      if_instr    <= imem_rdata;
      fetch_count <= fetch_count + 32'd1;
    end else if (release_ifid) begin
      if_valid    <= 1'b0;
      if_instr    <= NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] nextpc;
  logic        flush;
  logic        id_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  // Reference model: what fetch is doing, described by its obligations.
  logic [31:0] m_pc;
  bit          m_inflight;   // request accepted, its word not yet returned
  bit          m_stale;      // that word belongs to an abandoned address
  bit          m_valid;
  logic [31:0] m_ifpc;
  logic [31:0] m_instr;
  logic [31:0] m_count;

  int mem_wait = 0;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .nextpc(nextpc), .flush(flush), .id_stall(id_stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pc(pc),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_req();
    return !m_inflight && !m_valid;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_inflight = 0; m_stale = 0; m_valid = 0;
    m_ifpc = RST_PC; m_instr = NOP; m_count = 0;
  endtask

  // Compare every output with the model, advance the model by this cycle's inputs, clock.
  task automatic cycle();
    logic [31:0] npc;
    chk("imem_req",    {31'd0, imem_req}, {31'd0, m_req()});
    chk("imem_addr",   imem_addr, m_pc);
    chk("pc",          pc, m_pc);
    chk("if_valid",    {31'd0, if_valid}, {31'd0, m_valid});
    chk("if_pc",       if_pc, m_ifpc);
    chk("if_instr",    if_instr, m_instr);
    chk("fetch_count", fetch_count, m_count);
    npc = {nextpc[31:2], 2'b00};
    if (rst) begin
      model_reset();
    end else if (m_valid) begin
      if (flush || !id_stall) begin
        m_pc = npc; m_valid = 0; m_instr = NOP;
      end
    end else if (m_inflight) begin
      if (imem_rvalid) begin
        if (!m_stale && !flush) begin
          m_valid = 1; m_ifpc = m_pc; m_instr = imem_rdata; m_count = m_count + 1;
        end
        m_inflight = 0; m_stale = 0;
        if (flush) m_pc = npc;
      end else if (flush) begin
        m_pc = npc; m_stale = 1;
      end
    end else begin
      if (imem_ready) begin
        m_inflight = 1; m_stale = flush;
      end
      if (flush) m_pc = npc;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit acc;
    rst = 1; nextpc = 0; flush = 0; id_stall = 0;
    imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
    model_reset();
    @(posedge clk); #1;
    cycle();

    // Reset values and best-case fetch of the first word.
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    rst = 0; imem_ready = 1; nextpc = 32'h4;
    chk("c0_addr", imem_addr, 32'h0);
    chk("c0_req", {31'd0, imem_req}, 32'd1);
    cycle();
    imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h2008_0005;
    cycle();
    imem_rvalid = 0;
    chk("c2_valid", {31'd0, if_valid}, 32'd1);
    chk("c2_ifpc", if_pc, 32'h0);
    chk("c2_instr", if_instr, 32'h2008_0005);
    chk("c2_count", fetch_count, 32'd1);
    cycle();
    chk("c3_addr", imem_addr, 32'h4);

    // Request held while memory is not ready.
    imem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      chk("hold_req", {31'd0, imem_req}, 32'd1);
      chk("hold_addr", imem_addr, 32'h4);
      cycle();
    end
    imem_ready = 1;
    cycle();
    chk("wait_after_ready", {31'd0, imem_req}, 32'd0);
    imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h1234_5678; id_stall = 1;
    cycle();
    imem_rvalid = 0; nextpc = 32'h40;

    // Decode stall holds the IF/ID register and the PC.
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_ifpc", if_pc, 32'h4);
      chk("stall_instr", if_instr, 32'h1234_5678);
      chk("stall_pc", pc, 32'h4);
      chk("stall_noreq", {31'd0, imem_req}, 32'd0);
    end
    id_stall = 0;
    cycle();
    chk("unstall_addr", imem_addr, 32'h40);

    // Flush while waiting: the late word is thrown away.
    imem_ready = 1;
    cycle();
    imem_ready = 0; flush = 1; nextpc = 32'h8000_0180;
    cycle();
    flush = 0;
    cycle();
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    cycle();
    imem_rvalid = 0;
    chk("wflush_valid", {31'd0, if_valid}, 32'd0);
    chk("wflush_addr", imem_addr, 32'h8000_0180);
    chk("wflush_req", {31'd0, imem_req}, 32'd1);
    chk("wflush_count", fetch_count, 32'd2);

    // Flush coinciding with acceptance in REQ.
    flush = 1; nextpc = 32'h8;
    cycle();
    chk("redir_pc8", imem_addr, 32'h8);
    imem_ready = 1; nextpc = 32'h103;
    cycle();
    flush = 0; imem_ready = 0;
    chk("racc_addr", imem_addr, 32'h100);
    imem_rvalid = 1; imem_rdata = 32'hCAFE_0001;
    cycle();
    imem_rvalid = 0;
    chk("racc_valid", {31'd0, if_valid}, 32'd0);
    chk("racc_next", imem_addr, 32'h100);
    chk("racc_req", {31'd0, imem_req}, 32'd1);

    // Reset while waiting, with the old response arriving afterwards.
    imem_ready = 1;
    cycle();
    imem_ready = 0; rst = 1;
    cycle();
    rst = 0; imem_rvalid = 1; imem_rdata = 32'h0BAD_0BAD;
    cycle();
    imem_rvalid = 0;
    chk("late_valid", {31'd0, if_valid}, 32'd0);
    chk("late_addr", imem_addr, RST_PC);
    chk("late_count", fetch_count, 32'd0);
    chk("late_req", {31'd0, imem_req}, 32'd1);

    // Randomized traffic against the model, including spurious rvalid and resets.
    mem_wait = 0;
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 99) == 0);
      flush      = ($urandom_range(0, 7) == 0);
      id_stall   = ($urandom_range(0, 2) == 0);
      imem_ready = ($urandom_range(0, 2) != 0);
      nextpc     = $urandom;
      imem_rdata = $urandom;
      imem_rvalid = (mem_wait == 1) || (!m_inflight && $urandom_range(0, 9) == 0);
      acc = m_req() && imem_ready && !rst;
      cycle();
      if (rst) mem_wait = 0;
      else if (mem_wait > 0) mem_wait--;
      if (acc) mem_wait = $urandom_range(1, 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
